// File: rtl/bcd_countdown_timer.sv
// BCD hh:mm:ss countdown: loads saturated preset in state 0/1/2, counts down once per second in state 3, alarms at zero.
// Load latency 1 cycle; no backpressure. ALARM_BLINK_EN: alarm toggles every second while expired.
module bcd_countdown_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic [23:0] controlledToggleSwitchBits,
  output logic [23:0] currentBits,
  output logic        running,
  output logic        alarm,
  output logic        secPulse
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} fsm_t;

  fsm_t          fsm, fsm_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [23:0]   cur_nxt, dec;
  logic          alarm_nxt;
  logic          is_start, is_load;

  function automatic logic [23:0] saturate(input logic [23:0] p);
    logic [3:0] h1, h0, m1, m0, s1, s0, cap;
    h1  = (p[23:20] > 4'd1) ? 4'd1 : p[23:20];
    cap = (h1 == 4'd0) ? 4'd9 : 4'd2;
    h0  = (p[19:16] > cap) ? cap : p[19:16];
    m1  = (p[15:12] > 4'd5) ? 4'd5 : p[15:12];
    m0  = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
    s1  = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
    s0  = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  // Ripple borrow through the digits; hours behave as a plain two-digit decimal.
  function automatic logic [23:0] dec_sec(input logic [23:0] t);
    logic [23:0] r;
    logic        b;
    r = t;
    b = 1'b1;
    if (t != 24'h0) begin
      if (r[3:0] != 4'd0) begin r[3:0] = r[3:0] - 4'd1; b = 1'b0; end
      else r[3:0] = 4'd9;
      if (b) begin
        if (r[7:4] != 4'd0) begin r[7:4] = r[7:4] - 4'd1; b = 1'b0; end
        else r[7:4] = 4'd5;
      end
      if (b) begin
        if (r[11:8] != 4'd0) begin r[11:8] = r[11:8] - 4'd1; b = 1'b0; end
        else r[11:8] = 4'd9;
      end
      if (b) begin
        if (r[15:12] != 4'd0) begin r[15:12] = r[15:12] - 4'd1; b = 1'b0; end
        else r[15:12] = 4'd5;
      end
      if (b) begin
        if (r[19:16] != 4'd0) begin r[19:16] = r[19:16] - 4'd1; b = 1'b0; end
        else r[19:16] = 4'd9;
      end
      if (b) r[23:20] = r[23:20] - 4'd1;
    end
    return r;
  endfunction

  assign is_start = (state == 4'd3);
  assign is_load  = (state < 4'd3);
  assign dec      = dec_sec(currentBits);
  assign running  = (fsm == RUN);

`ifdef ALARM_BLINK_EN
  assign secPulse = ((fsm == RUN) || (fsm == EXPIRED)) && (presc == TERM);
`else
  assign secPulse = (fsm == RUN) && (presc == TERM);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt   = fsm;
    presc_nxt = '0;
    cur_nxt   = currentBits;
    alarm_nxt = 1'b0;
    // Leaving state 3 beats any same-cycle decrement.
    if (!is_start) begin
      fsm_nxt = IDLE;
      if (is_load) cur_nxt = saturate(controlledToggleSwitchBits);
    end else begin
      case (fsm)
        IDLE: begin
          if (currentBits == 24'h0) begin
            fsm_nxt   = EXPIRED;
            alarm_nxt = 1'b1;
          end else begin
            fsm_nxt = RUN;
          end
        end
        RUN: begin
          presc_nxt = secPulse ? '0 : presc + PW'(1);
          if (secPulse) begin
            cur_nxt = dec;
            if (dec == 24'h0) begin
              fsm_nxt   = EXPIRED;
              alarm_nxt = 1'b1;
            end
          end
        end
        EXPIRED: begin
          cur_nxt = 24'h0;
`ifdef ALARM_BLINK_EN
          presc_nxt = secPulse ? '0 : presc + PW'(1);
          alarm_nxt = secPulse ? ~alarm : alarm;
`else
          alarm_nxt = 1'b1;
`endif
        end
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      currentBits <= 24'h125959;
      presc       <= '0;
      alarm       <= 1'b0;
    end else begin
      currentBits <= cur_nxt;
      presc       <= presc_nxt;
      alarm       <= alarm_nxt;
    end
  end

endmodule
